// File: rtl/mux3_scan_pkg.sv
// Shared definitions for the 3:1 selector scan controller: FSM states,
// select-line encodings and the settle counter width.
package mux3_scan_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] SEL_U_CODE    = 2'b00;
    localparam logic [1:0] SEL_V_CODE    = 2'b01;
    localparam logic [1:0] SEL_W_CODE    = 2'b10;
    localparam logic [1:0] SEL_IDLE_CODE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL_U = 3'd1,
        ST_SEL_V = 3'd2,
        ST_SEL_W = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Select code {s1,s0} driven while the FSM sits in a given state.
    function automatic logic [1:0] sel_code(input state_e st);
        logic [1:0] code;
        case (st)
            ST_SEL_U: code = SEL_U_CODE;
            ST_SEL_V: code = SEL_V_CODE;
            ST_SEL_W: code = SEL_W_CODE;
            default:  code = SEL_IDLE_CODE;
        endcase
        return code;
    endfunction

    // True for the three states in which a source is selected and settling.
    function automatic logic is_sel_state(input state_e st);
        logic r;
        case (st)
            ST_SEL_U, ST_SEL_V, ST_SEL_W: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts while enabled, clears on request, and flags
// the last cycle of the settle window (count == SETTLE_CYCLES-1).
module settle_timer
    import mux3_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over counting; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mux3_scan_ctrl.sv
// Scan controller for the two-stage 3:1 selector: steps the selects through
// u, v, w, samples m after each settle window and reports the captured
// pattern with a pass/fail compare against a latched expected pattern.
// All outputs are registered so the selects never glitch from the counter.
module mux3_scan_ctrl
    import mux3_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] expected,
    input  logic       m,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       done,
    output logic [2:0] sample,
    output logic       pass
);

    state_e     state_q,    state_d;
    logic [2:0] expected_q, expected_d;
    logic [2:0] sample_q,   sample_d;
    logic [1:0] sel_q,      sel_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       pass_q,     pass_d;

    logic       tc_s;
    logic       clr_s;
    logic       en_s;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_s),
        .en_i  (en_s),
        .tc_o  (tc_s)
    );

    // Next-state, capture and output-register inputs for the scan sequence.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        sample_d   = sample_q;
        pass_d     = pass_q;
        clr_s      = 1'b0;
        en_s       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Counter held at zero so every scan starts a fresh window.
                clr_s = 1'b1;
                if (start) begin
                    state_d    = ST_SEL_U;
                    expected_d = expected;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_SEL_U: begin
                if (tc_s) begin
                    sample_d[0] = m;
                    clr_s       = 1'b1;
                    state_d     = ST_SEL_V;
                end else begin
                    en_s        = 1'b1;
                end
            end
            ST_SEL_V: begin
                if (tc_s) begin
                    sample_d[1] = m;
                    clr_s       = 1'b1;
                    state_d     = ST_SEL_W;
                end else begin
                    en_s        = 1'b1;
                end
            end
            ST_SEL_W: begin
                if (tc_s) begin
                    sample_d[2] = m;
                    clr_s       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    en_s        = 1'b1;
                end
            end
            default: begin
                clr_s   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Selects and busy follow the state being entered, so they are
        // registered alongside it and change only on transitions.
        sel_d  = sel_code(state_d);
        busy_d = is_sel_state(state_d);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);

        if (done_d) begin
            pass_d = (sample_d == expected_q);
        end else begin
            pass_d = pass_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            expected_q <= 3'b000;
            sample_q   <= 3'b000;
            sel_q      <= SEL_IDLE_CODE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            sample_q   <= sample_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign s0     = sel_q[0];
    assign s1     = sel_q[1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;
    assign pass   = pass_q;

endmodule
